// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            hold,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [2:0]        fn_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   rem_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CW-1:0]     cnt_q;
  logic              negq_q;
  logic              negr_q;
  logic              done_q;
  logic [XLEN-1:0]   res_q;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0, ovf;
  logic [XLEN-1:0] spec_res;

  // MUL low word is sign-agnostic, so it is treated as unsigned.
  assign a_sgn = (funct3 == 3'b001) | (funct3 == 3'b010)
               | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign b_sgn = (funct3 == 3'b001) | (funct3 == 3'b100)
               | (funct3 == 3'b110);
  assign a_neg = a_sgn & op_a[XLEN-1];
  assign b_neg = b_sgn & op_b[XLEN-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  assign div0 = funct3[2] & (op_b == '0);
  assign ovf  = funct3[2] & ~funct3[0]
              & (op_a == {1'b1, {(XLEN-1){1'b0}}})
              & (op_b == '1);
  assign spec_res = funct3[1] ? (div0 ? op_a : '0)
                              : (div0 ? '1 : op_a);

  logic [XLEN:0]     shifted, trial;
  logic [XLEN-1:0]   rem_nx, quo_nx;
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] prod_nx;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, a_q};
  assign rem_nx  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ~trial[XLEN]};

  assign msum    = {1'b0, prod_q[2*XLEN-1:XLEN]}
                 + {1'b0, (prod_q[0] ? a_q : {XLEN{1'b0}})};
  assign prod_nx = {msum, prod_q[XLEN-1:1]};

  logic [2*XLEN-1:0] prod_fx;
  logic [XLEN-1:0]   quo_fx, rem_fx, fx_res;

  assign prod_fx = negq_q ? -prod_q : prod_q;
  assign quo_fx  = negq_q ? -quo_q : quo_q;
  assign rem_fx  = negr_q ? -rem_q : rem_q;

  always_comb begin
    fx_res = '0;
    unique case (1'b1)
      fn_q[2] & fn_q[1]:              fx_res = rem_fx;
      fn_q[2] & ~fn_q[1]:             fx_res = quo_fx;
      ~fn_q[2] & (fn_q[1:0] == 2'b0): fx_res = prod_fx[XLEN-1:0];
      ~fn_q[2] & (fn_q[1:0] != 2'b0): fx_res = prod_fx[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = start & ~flush;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fn_q    <= '0;
      a_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          fn_q   <= funct3;
          cnt_q  <= '0;
          negq_q <= a_neg ^ b_neg;
          negr_q <= a_neg;
          rem_q  <= '0;
          if (funct3[2]) begin
            quo_q <= a_mag;
            a_q   <= b_mag;
          end else begin
            prod_q <= {{XLEN{1'b0}}, b_mag};
            a_q    <= a_mag;
          end
          if (div0 | ovf) begin
            res_q   <= spec_res;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: if (cnt_q == CW'(XLEN)) begin
          res_q   <= fx_res;
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          if (fn_q[2]) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
          end else begin
            prod_q <= prod_nx;
          end
        end
        DONE: if (!hold) begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = res_q;

endmodule
